alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_issue_stage.sv | 112 +++++++++++
 tb/tb_alu_issue_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/retire stage.
// Opcodes, FSM encoding, and the packed command/result records.
package alu_pkg;

    localparam int DW = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    localparam logic [DW-1:0] DBZ_RESULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    op;
    } cmd_t;

    typedef struct packed {
        logic [DW-1:0] y;
        logic [2:0]    op;
        logic          zero;
        logic          dbz;
    } res_t;

    // Divide by zero overrides whatever the ALU produced; zero flag follows the final value.
    function automatic res_t make_result(input logic [2:0] op, input logic [DW-1:0] b,
                                         input logic [DW-1:0] y);
        res_t r;
        r.dbz  = (op == OP_DIV) && (b == '0);
        r.y    = r.dbz ? DBZ_RESULT : y;
        r.op   = op;
        r.zero = (r.y == '0);
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_stage.sv
// Purpose: registers commands into the external ALU and retires flagged results.
// Latency: accepted command's result is valid two cycles later; one command per 2 cycles max.
// Backpressure: result holds while out_ready=0; in_ready follows out_ready in DONE, 0 in EXEC.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    input  logic [2:0]       in_op,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [2:0]       alu_op,
    input  logic [DW-1:0]    alu_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_y,
    output logic [2:0]       out_op,
    output logic             out_zero,
    output logic             out_dbz,
    output logic [CNT_W-1:0] retired
);

    state_t            state, state_nxt;
    logic              accept;
    logic              retire;
    cmd_t              cmd_q;
    res_t              res_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    retire = 1'b1;
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands only move on acceptance so the ALU inputs stay quiet while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            if (accept) begin
                cmd_q <= '{a: in_a, b: in_b, op: in_op};
            end
            if (state == EXEC) begin
                res_q       <= make_result(cmd_q.op, cmd_q.b, alu_y);
                out_valid_q <= 1'b1;
            end else if (retire) begin
                out_valid_q <= 1'b0;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign alu_a     = cmd_q.a;
    assign alu_b     = cmd_q.b;
    assign alu_op    = cmd_q.op;
    assign out_valid = out_valid_q;
    assign out_y     = res_q.y;
    assign out_op    = res_q.op;
    assign out_zero  = res_q.zero;
    assign out_dbz   = res_q.dbz;
    assign retired   = retired_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural ALU beside it and a cycle-level reference model.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a, in_b;
    logic [2:0]       in_op;
    logic [7:0]       alu_a, alu_b;
    logic [2:0]       alu_op;
    logic [7:0]       alu_y;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_y;
    logic [2:0]       out_op;
    logic             out_zero;
    logic             out_dbz;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    // External ALU; divide by zero deliberately yields a junk value the stage must discard.
    always_comb begin
        alu_y = 8'h00;
        case (alu_op)
            OP_ADD:  alu_y = alu_a + alu_b;
            OP_SUB:  alu_y = alu_a - alu_b;
            OP_MUL:  alu_y = alu_a * alu_b;
            OP_DIV:  alu_y = (alu_b == 8'h00) ? 8'h5A : alu_a / alu_b;
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_NOT:  alu_y = ~alu_a;
            default: alu_y = alu_a ^ alu_b;
        endcase
    end

    alu_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_dbz   (out_dbz),
        .retired   (retired)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [7:0] y;
        logic [2:0] op;
        logic       dbz;
    } exp_t;

    // Reference model state: pending result, when it was accepted, retirement count, ALU operand view.
    exp_t       exp_q[$];
    bit         outstanding = 0;
    int         acc_cyc     = 0;
    int         cyc         = 0;
    int         exp_retired = 0;
    int         m_a = 0, m_b = 0, m_op = 0;
    logic [7:0] last_y;
    logic       last_zero, last_dbz;
    bit         out_fire_seen;

    function automatic exp_t ref_model(input int a, input int b, input int op);
        exp_t e;
        int   r;
        e.dbz = 1'b0;
        case (op)
            0: r = a + b;
            1: r = a - b + 256;
            2: r = a * b;
            3: begin
                if (b == 0) begin
                    r     = 255;
                    e.dbz = 1'b1;
                end else begin
                    r = a / b;
                end
            end
            4: r = a & b;
            5: r = a | b;
            6: r = 255 - a;
            default: r = a ^ b;
        endcase
        e.y  = 8'(r % 256);
        e.op = 3'(op);
        return e;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        exp_retired = 0;
        m_a = 0; m_b = 0; m_op = 0;
    endtask

    // One cycle: drive at negedge, check 1ns later, advance model on predicted handshakes.
    task automatic run_cycle(input bit iv, input int a, input int b, input int op, input bit ordy);
        bit exp_valid, exp_rdy, in_fire, out_fire;
        in_valid  = iv;
        in_a      = 8'(a);
        in_b      = 8'(b);
        in_op     = 3'(op);
        out_ready = ordy;
        #1;
        exp_valid = outstanding && (cyc >= acc_cyc + 2);
        exp_rdy   = !outstanding || (exp_valid && ordy);
        chk("out_valid", out_valid, exp_valid);
        chk("in_ready", in_ready, exp_rdy);
        chk("retired", retired, exp_retired);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
        if (exp_valid && exp_q.size() > 0) begin
            chk("out_y", out_y, exp_q[0].y);
            chk("out_op", out_op, exp_q[0].op);
            chk("out_zero", out_zero, exp_q[0].y == 8'h00);
            chk("out_dbz", out_dbz, exp_q[0].dbz);
        end
        in_fire  = iv && exp_rdy;
        out_fire = exp_valid && ordy;
        out_fire_seen = out_fire;
        if (out_fire) begin
            last_y    = out_y;
            last_zero = out_zero;
            last_dbz  = out_dbz;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_retired = (exp_retired + 1) % (1 << CNT_W);
            outstanding = 0;
        end
        if (in_fire) begin
            exp_q.push_back(ref_model(a, b, op));
            m_a = a; m_b = b; m_op = op;
            outstanding = 1;
            acc_cyc     = cyc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic one_cmd(input int a, input int b, input int op);
        run_cycle(1, a, b, op, 1);
        run_cycle(0, 0, 0, 0, 1);
        run_cycle(0, 0, 0, 0, 1);
    endtask

    initial begin
        int r0, idx, ncyc;
        int cmds_a[4] = '{8'h01, 8'h80, 8'hAA, 8'h07};
        int cmds_b[4] = '{8'h02, 8'h03, 8'h55, 8'h07};
        int cmds_o[4] = '{0, 2, 5, 1};

        rst_n = 1'b0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_dbz", out_dbz, 0);
        chk("rst_retired", retired, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single add
        one_cmd(8'h12, 8'h34, 0);
        chk("add_y", last_y, 8'h46);
        chk("add_zero", last_zero, 0);
        chk("add_retired", retired, 1);

        // Divide by zero, then a normal divide
        one_cmd(8'h40, 8'h00, 3);
        chk("dbz_y", last_y, 8'hFF);
        chk("dbz_flag", last_dbz, 1);
        chk("dbz_zero", last_zero, 0);
        one_cmd(8'h40, 8'h08, 3);
        chk("div_y", last_y, 8'h08);
        chk("div_dbz", last_dbz, 0);

        // Zero flag and truncation
        one_cmd(8'h05, 8'h05, 1);
        chk("sub_zero", last_zero, 1);
        one_cmd(8'h10, 8'h10, 2);
        chk("mul_y", last_y, 8'h00);
        chk("mul_zero", last_zero, 1);

        // Backpressure: result held, new command refused
        r0 = exp_retired;
        run_cycle(1, 8'hF0, 8'h3C, 7, 1);
        run_cycle(0, 0, 0, 0, 0);
        repeat (5) run_cycle(1, 8'h11, 8'h22, 0, 0);
        chk("bp_retired_hold", retired, r0);
        run_cycle(0, 0, 0, 0, 1);
        chk("bp_y", last_y, 8'hCC);
        chk("bp_retired", retired, (r0 + 1) % (1 << CNT_W));

        // Back-to-back with in_valid held high
        r0 = exp_retired; idx = 0; ncyc = 0;
        for (int k = 0; k < 40 && ((retired - r0) & ((1 << CNT_W) - 1)) < 4; k++) begin
            run_cycle(idx < 4, idx < 4 ? cmds_a[idx] : 0, idx < 4 ? cmds_b[idx] : 0,
                      idx < 4 ? cmds_o[idx] : 0, 1);
            ncyc++;
            if (idx < 4 && m_a == cmds_a[idx] && outstanding && acc_cyc == cyc - 1) idx++;
        end
        chk("b2b_count", (retired - r0) & ((1 << CNT_W) - 1), 4);
        chk("b2b_cycles", ncyc, 9);

        // Asynchronous reset while a result is in EXEC
        run_cycle(1, 8'h21, 8'h03, 2, 1);
        in_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_retired", retired, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_alu_b", alu_b, 0);
        chk("arst_alu_op", alu_op, 0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        one_cmd(8'h07, 8'h06, 2);
        chk("post_rst_y", last_y, 8'h2A);
        chk("post_rst_retired", retired, 1);

        // Randomized traffic, includes wrap of the retired counter
        for (int k = 0; k < 400; k++) begin
            run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
                      $urandom_range(0, 7), $urandom_range(0, 3) != 0);
        end
        repeat (4) run_cycle(0, 0, 0, 0, 1);
        chk("drain_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
